// File: rtl/lcd_hd44780_pkg.sv
// rtl/lcd_hd44780_pkg.sv - shared types and constants for the HD44780 controller
package lcd_hd44780_pkg;

   typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, DONE} state_t;

   localparam int RS_BIT = 1;
   localparam int RW_BIT = 0;

   localparam int DEF_SETUP_CYC = 2;
   localparam int DEF_PULSE_CYC = 24;
   localparam int DEF_HOLD_CYC  = 24;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/lcd_hd44780_if.sv
// rtl/lcd_hd44780_if.sv - host-side register bus of the LCD controller
interface lcd_hd44780_if;
   logic [1:0] address;
   logic       read;
   logic       write;
   logic [7:0] writedata;
   logic [7:0] readdata;
   logic       waitrequest;

   modport master (output address, read, write, writedata, input readdata, waitrequest);
   modport slave  (input address, read, write, writedata, output readdata, waitrequest);
endinterface

// File: rtl/lcd_phase_timer.sv
// rtl/lcd_phase_timer.sv - loadable down-counter; tc marks the last cycle of a phase
module lcd_phase_timer #(
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             tc
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (count != '0)
         count <= count - 1'b1;
   end

   assign tc = (count == '0);

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// rtl/lcd_hd44780_ctrl.sv - bus slave generating HD44780 setup/enable/hold timing
module lcd_hd44780_ctrl
   import lcd_hd44780_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int SETUP_CYC = DEF_SETUP_CYC,
   parameter int PULSE_CYC = DEF_PULSE_CYC,
   parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
   input  logic              clk,
   input  logic              reset,
   lcd_hd44780_if.slave      bus,
   output logic              LCD_E,
   output logic              LCD_RS,
   output logic              LCD_RW,
   inout  wire  [DATA_W-1:0] LCD_data
);

   localparam int CNT_W = $clog2(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC) + 1);

   state_t           state, state_nxt;
   logic [7:0]       wr_byte, rd_byte, dout8;
   logic             beat, tc, load, drive, sample, req, lcd_op, rw_in;
   logic [CNT_W-1:0] load_val;

   assign req    = bus.read | bus.write;
   // A simultaneous read+write is a write with RW forced low, so it always reaches the LCD.
   assign rw_in  = bus.write ? 1'b0 : bus.address[RW_BIT];
   assign lcd_op = bus.write ? (bus.read | ~bus.address[RW_BIT]) : bus.address[RW_BIT];

   lcd_phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .load_val (load_val),
      .tc       (tc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  if (req) state_nxt = lcd_op ? SETUP : DONE;
         SETUP: if (tc) state_nxt = PULSE;
         PULSE: if (tc) state_nxt = HOLD;
         HOLD:  if (tc) state_nxt = (DATA_W == 4 && !beat) ? SETUP : DONE;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      load     = (state_nxt != state) && (state_nxt inside {SETUP, PULSE, HOLD});
      load_val = '0;
      unique case (state_nxt)
         SETUP:   load_val = CNT_W'(SETUP_CYC - 1);
         PULSE:   load_val = CNT_W'(PULSE_CYC - 1);
         HOLD:    load_val = CNT_W'(HOLD_CYC - 1);
         default: load_val = '0;
      endcase
      drive           = (state inside {SETUP, PULSE, HOLD}) && !LCD_RW;
      sample          = (state == PULSE) && tc && LCD_RW;
      bus.waitrequest = req && (state != DONE);
   end

   always_comb begin
      dout8 = wr_byte;
      if (DATA_W == 4)
         dout8 = beat ? {4'h0, wr_byte[3:0]} : {4'h0, wr_byte[7:4]};
   end

   assign LCD_data = drive ? DATA_W'(dout8) : {DATA_W{1'bz}};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         LCD_E        <= 1'b0;
         LCD_RS       <= 1'b0;
         LCD_RW       <= 1'b0;
         wr_byte      <= 8'h00;
         rd_byte      <= 8'h00;
         beat         <= 1'b0;
         bus.readdata <= 8'h00;
      end else begin
         LCD_E <= (state_nxt == PULSE);
         if (state == IDLE && req) begin
            LCD_RS  <= bus.address[RS_BIT];
            LCD_RW  <= rw_in;
            wr_byte <= bus.writedata;
            rd_byte <= 8'h00;
            beat    <= 1'b0;
         end
         if (state == HOLD && state_nxt == SETUP)
            beat <= 1'b1;
         if (sample) begin
            if (DATA_W == 8)  rd_byte      <= 8'(LCD_data);
            else if (beat)    rd_byte[3:0] <= LCD_data[3:0];
            else              rd_byte[7:4] <= LCD_data[3:0];
         end
         // Non-LCD reads finish straight from IDLE and always return zero.
         if (state == IDLE && state_nxt == DONE && !bus.write)
            bus.readdata <= 8'h00;
         else if (state == HOLD && state_nxt == DONE && LCD_RW)
            bus.readdata <= rd_byte;
      end
   end

endmodule

// File: doc/lcd_hd44780_ctrl.md
# lcd_hd44780_ctrl

Parametrised Avalon-MM slave driving an HD44780/16207-class character LCD with cycle-accurate bus timing. It replaces the purely combinational LCD pass-through, where E simply followed read|write. A timing FSM now generates setup, enable-pulse and hold phases from clock-cycle parameters. The host is stalled with waitrequest, and 4-bit (nibble) mode is supported as well as 8-bit. It sits on the processor's Avalon fabric next to the other peripheral slaves.

## Interface
- DATA_W, 8, LCD data bus width; legal values 8 or 4 (4 = nibble mode on D7..D4)
- SETUP_CYC, 2, cycles RS/RW/data are stable before E rises (≥1)
- PULSE_CYC, 24, cycles E is high (≥1)
- HOLD_CYC, 24, cycles E is low after the pulse before the next beat or completion (≥1)
- clk  in  1  system clock; one clock domain
- reset  in  1  asynchronous, active-high reset
- address  in  2  [1]=RS, [0]=RW (1 = read from LCD)
- read  in  1  Avalon read
- write  in  1  Avalon write
- writedata  in  8  command/data byte
- readdata  out  8  byte read from LCD; registered
- waitrequest  out  1  stalls host while a transfer is in progress
- LCD_E  out  1  enable strobe; registered
- LCD_RS  out  1  register select; registered
- LCD_RW  out  1  read/write; registered
- LCD_data  inout  DATA_W  LCD bus; tri-stated unless writing

## Operation
- States: IDLE, SETUP, PULSE, HOLD, DONE. One down-counter, width $clog2(max(SETUP_CYC,PULSE_CYC,HOLD_CYC)+1), is loaded on each phase entry.
- IDLE:
  - On read|write, latch RS=address[1], RW=address[0] and the write byte, clear the beat index, then go to SETUP.
  - If read and write are both high, write wins and RW is forced to 0.
- Non-LCD requests:
  - write with address[0]=1 goes straight to DONE with no LCD cycle; the write is discarded.
  - read with address[0]=0 goes to DONE with readdata=0x00.
- SETUP: E=0; RS/RW/data driven. After SETUP_CYC cycles, go to PULSE.
- PULSE: E=1. On the last PULSE cycle, when RW=1, sample LCD_data into the current byte/nibble slot. Then go to HOLD.
- HOLD: E=0; data still driven for writes. After HOLD_CYC cycles:
  - In 4-bit mode with beat 0 done, go to SETUP for beat 1.
  - Otherwise go to DONE.
- Nibble order (DATA_W=4): beat 0 carries bits [7:4], beat 1 carries bits [3:0]. Read nibbles assemble in the same order.
- DONE: lasts one cycle. readdata is updated with the assembled byte (reads only) and held until the next read completes. Then return to IDLE.
- waitrequest = (read|write) & (state != DONE). It is combinational, so it is high whenever a request is pending and not completing, including during reset.
- LCD_data is driven only in SETUP/PULSE/HOLD with RW=0; it is high-Z in every other state.

## Timing
- Reset values: state IDLE, LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_data high-Z, readdata=0x00, counter 0.
- A request first seen in IDLE at cycle 0 completes (waitrequest low) at cycle 1 + N·(SETUP_CYC+PULSE_CYC+HOLD_CYC), where N=1 for 8-bit and N=2 for 4-bit.
  - Defaults: 51 cycles (8-bit), 101 cycles (4-bit).
- Non-LCD requests complete at cycle 1.
- A back-to-back request held high in DONE is not re-accepted until IDLE, giving a minimum gap of 1 IDLE cycle between transfers.
- The default E cycle is 50 clk = 1000 ns at 50 MHz, with a 480 ns pulse, which meets HD44780 limits.
- Reset mid-transfer clears E and the tri-state asynchronously. The aborted transfer produces no DONE.
- Host signals must be held stable while waitrequest is high (Avalon rule). Changes mid-transfer are ignored because the values were latched in IDLE.

## Structure
- Package lcd_hd44780_pkg holds:
  - the state enum
  - address bit positions (RS_BIT=1, RW_BIT=0)
  - default timing constants
- Optional sub-module lcd_phase_timer: loadable down-counter with a terminal-count flag. The FSM, beat index and data path stay in the top module.

## Test plan
- 8-bit write: addr=2'b10, writedata=0x41 → RS=1, RW=0, LCD_data=0x41 from cycle 1; E high for exactly 24 cycles starting at cycle 3; waitrequest low only at cycle 51.
- 8-bit read: addr=2'b01, model drives 0x80 during PULSE → readdata=0x80 at cycle 51; LCD_data never driven by the DUT.
- DATA_W=4 write of 0x3C → two E pulses carrying nibble 0x3 then 0xC; completion at cycle 101. A 4-bit read assembling 0xA then 0x5 → readdata=0xA5.
- Non-LCD requests: write to addr=2'b01 and read from addr=2'b00 → each completes at cycle 1; no E pulse; read returns 0x00.
- Reset asserted during PULSE → E=0 and bus high-Z in the same cycle; after release, state IDLE and the next write completes normally in 51 cycles.
- Parameter sweep SETUP/PULSE/HOLD = 1/1/1 and 5/40/10 → E width and completion cycle match the formula; read and write asserted together are treated as a write.
